// File: rtl/midi_msg_parser.sv
// midi_msg_parser: MIDI byte-stream parser with channel filter and show-ahead message FIFO.
// Define MIDI_RUNNING_STATUS_EN to enable running status.
module midi_msg_parser #(
  parameter int FIFO_DEPTH = 4,
  parameter bit VEL0_IS_OFF = 1'b1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          byte_valid_in,
  input  logic [7:0]                    byte_in,
  input  logic [15:0]                   channel_mask_in,
  output logic                          msg_valid_out,
  input  logic                          msg_ready_in,
  output logic [7:0]                    msg_status_out,
  output logic [6:0]                    msg_data1_out,
  output logic [6:0]                    msg_data2_out,
  output logic [1:0]                    msg_len_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic [7:0]                    drop_count_out
);
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;
  state_t state, state_nx;
  logic [7:0] status_r, status_nx;
  logic [6:0] d1_r, d1_nx;
  logic rs_valid, rs_nx;
  logic emit;
  logic [7:0] e_status, fin_status;
  logic [6:0] e_d1, e_d2;
  logic [1:0] e_len, need;
  logic voice, push_req, push, pop, full, drop;
  logic [23:0] mem [FIFO_DEPTH];
  logic [23:0] head;
  logic [AW:0] wr_ptr, rd_ptr;

  function automatic logic [1:0] len_of(input logic [7:0] s);
    return (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) ? 2'd1 :
           (s == 8'hF6) ? 2'd0 : 2'd2;
  endfunction

  assign need = len_of(status_r);

  always_comb begin
    state_nx = state;
    status_nx = status_r;
    d1_nx = d1_r;
    rs_nx = rs_valid;
    emit = 1'b0;
    e_status = status_r;
    e_d1 = 7'd0;
    e_d2 = 7'd0;
    e_len = 2'd0;
    if (byte_valid_in) begin
      if (byte_in >= 8'hF8) begin
        emit = 1'b1;
        e_status = byte_in;
      end else if (byte_in[7]) begin
        status_nx = byte_in;
        rs_nx = RS_EN && byte_in < 8'hF0;
        if (byte_in == 8'hF0) state_nx = SYSEX;
        else if (byte_in == 8'hF4 || byte_in == 8'hF5 || byte_in == 8'hF7) state_nx = IDLE;
        else if (byte_in == 8'hF6) begin
          state_nx = IDLE;
          emit = 1'b1;
          e_status = byte_in;
        end else state_nx = WAIT_D1;
      end else if (state == WAIT_D2 ||
                   ((state == WAIT_D1 || (state == IDLE && rs_valid)) && need == 2'd1)) begin
        emit = 1'b1;
        e_d1 = state == WAIT_D2 ? d1_r : byte_in[6:0];
        e_d2 = state == WAIT_D2 ? byte_in[6:0] : 7'd0;
        e_len = need;
        state_nx = rs_valid ? WAIT_D1 : IDLE;
      end else if (state == WAIT_D1 || (state == IDLE && rs_valid)) begin
        d1_nx = byte_in[6:0];
        state_nx = WAIT_D2;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      status_r <= 8'd0;
      d1_r <= 7'd0;
      rs_valid <= 1'b0;
    end else begin
      state <= state_nx;
      status_r <= status_nx;
      d1_r <= d1_nx;
      rs_valid <= rs_nx;
    end
  end

  // Note On with zero velocity is reported as Note Off when enabled
  assign voice = e_status < 8'hF0;
  assign fin_status = (VEL0_IS_OFF && e_status[7:4] == 4'h9 && e_len == 2'd2 && e_d2 == 7'd0) ?
                      {4'h8, e_status[3:0]} : e_status;
  assign push_req = emit && (!voice || channel_mask_in[e_status[3:0]]);
  assign fifo_count_out = wr_ptr - rd_ptr;
  assign msg_valid_out = fifo_count_out != '0;
  assign full = fifo_count_out == (AW+1)'(FIFO_DEPTH);
  assign pop = msg_valid_out && msg_ready_in;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  assign head = mem[rd_ptr[AW-1:0]];
  assign {msg_status_out, msg_data1_out, msg_data2_out, msg_len_out} = msg_valid_out ? head : '0;

  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr[AW-1:0]] <= {fin_status, e_d1, e_d2, e_len};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_count_out <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
    end
  end
endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: random and directed byte streams checked against a queue-based MIDI model.
module tb_midi_msg_parser;
  localparam int DEPTH = 4;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  logic clk_in = 1'b0, rst_in = 1'b1, byte_valid_in = 1'b0, msg_ready_in = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic [15:0] channel_mask_in = 16'hFFFF;
  logic msg_valid_out;
  logic [7:0] msg_status_out, drop_count_out;
  logic [6:0] msg_data1_out, msg_data2_out;
  logic [1:0] msg_len_out;
  logic [2:0] fifo_count_out;
  int n_cmp = 0, n_bad = 0;

  logic [23:0] q[$];
  logic [6:0] got[$];
  logic [7:0] cur, rs_st;
  bit sysex;
  int drops;

  midi_msg_parser #(.FIFO_DEPTH(DEPTH), .VEL0_IS_OFF(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_valid_in(byte_valid_in), .byte_in(byte_in),
    .channel_mask_in(channel_mask_in), .msg_valid_out(msg_valid_out), .msg_ready_in(msg_ready_in),
    .msg_status_out(msg_status_out), .msg_data1_out(msg_data1_out), .msg_data2_out(msg_data2_out),
    .msg_len_out(msg_len_out), .fifo_count_out(fifo_count_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [7:0] s);
    if (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) return 1;
    return 2;
  endfunction

  task automatic model_clear();
    q.delete(); got.delete();
    cur = 8'h00; rs_st = 8'h00; sysex = 0; drops = 0;
  endtask

  // one received byte -> zero or one message offered to the FIFO
  task automatic model_byte(input logic [7:0] b, output bit have, output logic [23:0] m);
    logic [7:0] st;
    have = 0; m = '0;
    if (b >= 8'hF8) begin
      have = 1; m = {b, 16'd0};
      return;
    end
    if (b[7]) begin
      sysex = (b == 8'hF0);
      got.delete();
      rs_st = (RS && b < 8'hF0) ? b : 8'h00;
      cur = (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) ? b : 8'h00;
      if (b == 8'hF6) begin
        have = 1; m = {b, 16'd0};
      end
      return;
    end
    if (sysex) return;
    if (cur == 8'h00) cur = rs_st;
    if (cur == 8'h00) return;
    got.push_back(b[6:0]);
    if (got.size() == nbytes(cur)) begin
      st = cur;
      if (cur[7:4] == 4'h9 && got.size() == 2 && got[1] == 7'd0) st = {4'h8, cur[3:0]};
      m = {st, got[0], (got.size() == 2) ? got[1] : 7'd0, 2'(got.size())};
      have = cur >= 8'hF0 || channel_mask_in[cur[3:0]];
      got.delete();
      cur = 8'h00;
    end
  endtask

  task automatic compare();
    logic [23:0] h;
    h = q.size() > 0 ? q[0] : 24'd0;
    chk("valid", msg_valid_out, q.size() > 0);
    chk("count", fifo_count_out, q.size());
    chk("drops", drop_count_out, drops);
    chk("status", msg_status_out, h[23:16]);
    chk("data1", msg_data1_out, h[15:9]);
    chk("data2", msg_data2_out, h[8:2]);
    chk("len", msg_len_out, h[1:0]);
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit rdy);
    bit have;
    logic [23:0] m;
    byte_valid_in = v; byte_in = b; msg_ready_in = rdy;
    have = 0; m = '0;
    if (v) model_byte(b, have, m);
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (have) begin
      if (q.size() < DEPTH) q.push_back(m);
      else if (drops < 255) drops++;
    end
    @(negedge clk_in);
    compare();
  endtask

  task automatic send(input logic [7:0] bs[$]);
    foreach (bs[i]) step(1, bs[i], 0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(0, 8'h00, 1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    model_clear();
    #1;
    chk("rst_valid", msg_valid_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_drops", drop_count_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    compare();
  endtask

  initial begin
    logic [7:0] b;
    int r;
    model_clear();
    @(negedge clk_in);
    do_reset();
    send('{8'h90, 8'h3C, 8'h64});
    chk("tp1_status", msg_status_out, 8'h90);
    chk("tp1_d1", msg_data1_out, 7'h3C);
    chk("tp1_d2", msg_data2_out, 7'h64);
    chk("tp1_len", msg_len_out, 2);
    drain();
    send('{8'h92, 8'h40, 8'h7F, 8'h41, 8'h00});
    drain();
    send('{8'h90, 8'h3C, 8'hF8, 8'h64});
    chk("rt_first", msg_status_out, 8'hF8);
    chk("rt_len", msg_len_out, 0);
    drain();
    send('{8'hC5, 8'h07});
    chk("pc_d2", msg_data2_out, 0);
    drain();
    channel_mask_in = 16'h0001;
    send('{8'h91, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64});
    chk("mask_count", fifo_count_out, 1);
    chk("mask_drops", drop_count_out, 0);
    drain();
    channel_mask_in = 16'hFFFF;
    do_reset();
    repeat (6) send('{8'hC5, 8'h07});
    chk("ovf_count", fifo_count_out, 4);
    chk("ovf_drops", drop_count_out, 2);
    drain();
    send('{8'hF0, 8'h01, 8'h02, 8'h03, 8'hF7, 8'hB0, 8'h07, 8'h40});
    chk("sysex_count", fifo_count_out, 1);
    chk("sysex_status", msg_status_out, 8'hB0);
    drain();
    send('{8'h90, 8'h3C});
    do_reset();
    send('{8'h64});
    chk("rst_mid", msg_valid_out, 0);
    repeat (300) step(1, 8'hF8, 0);
    chk("drop_sat", drop_count_out, 255);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) channel_mask_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      r = $urandom_range(0, 9);
      b = r < 5 ? 8'($urandom_range(0, 127)) : r < 8 ? 8'($urandom_range(8'h80, 8'hEF)) :
          r < 9 ? 8'($urandom_range(8'hF0, 8'hF7)) : 8'($urandom_range(8'hF8, 8'hFF));
      step($urandom_range(0, 9) < 7, b, $urandom_range(0, 1) == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
